// File: rtl/fetch_queue.sv
// fetch_queue: owns the fetch PC, drives instruction memory and buffers
// fetched words with their PC+4 in a small FIFO drained by decode.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN (zero-latency path when empty).
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [31:0]            inst_addr,
    input  logic [31:0]            inst,
    input  logic                   imem_ready,
    input  logic                   redirect_en,
    input  logic [31:0]            redirect_pc,
    input  logic                   halted,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_inst,
    output logic [31:0]            out_pc_plus_4,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]      fetch_pc;
    logic [31:0]      pc_plus_4;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      buf_inst [DEPTH];
    logic [31:0]      buf_pc4  [DEPTH];

    logic full;
    logic empty;
    logic q_pop;
    logic fetch_ok;
    logic q_push;
    logic bypass;
    logic unused_redirect_lsbs;

    // Target low bits are architecturally ignored.
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Push/pop/bypass qualification; redirect suppresses both push and pop.
    always_comb begin
        full      = (cnt == CNT_W'(DEPTH));
        empty     = (cnt == '0);
        pc_plus_4 = fetch_pc + 32'd4;
        q_pop     = !empty && out_ready && !redirect_en;
        fetch_ok  = imem_ready && !halted && !redirect_en && (!full || q_pop);
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass    = empty && fetch_ok && out_ready && !reset;
`else
        bypass    = 1'b0;
`endif
        q_push    = fetch_ok && !bypass;
    end

    // Fetch PC, pointers and occupancy; reset beats redirect beats push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
        end else if (redirect_en) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
        end else begin
            if (fetch_ok) begin
                fetch_pc <= pc_plus_4;
            end
            if (q_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (q_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (q_push && !q_pop) begin
                cnt <= cnt + CNT_W'(1);
            end else if (q_pop && !q_push) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Entry storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (!reset && q_push) begin
            buf_inst[wr_ptr] <= inst;
            buf_pc4[wr_ptr]  <= pc_plus_4;
        end
    end

    // Head-of-queue view for decode, zeroed when nothing is available.
    always_comb begin
        out_valid     = !empty;
        out_inst      = 32'd0;
        out_pc_plus_4 = 32'd0;
        if (!empty) begin
            out_inst      = buf_inst[rd_ptr];
            out_pc_plus_4 = buf_pc4[rd_ptr];
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        if (bypass) begin
            out_valid     = 1'b1;
            out_inst      = inst;
            out_pc_plus_4 = pc_plus_4;
        end
`endif
    end

    assign inst_addr = fetch_pc;
    assign count     = cnt;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus randomized traffic against a
// queue-based reference model of the fetch stage.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [31:0] BASE  = 32'h0040_0000;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      inst_addr;
    logic [31:0]      inst;
    logic             imem_ready;
    logic             redirect_en;
    logic [31:0]      redirect_pc;
    logic             halted;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_inst;
    logic [31:0]      out_pc_plus_4;
    logic [CNT_W-1:0] count;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of {inst, pc+4} and the fetch PC.
    logic [63:0] q [$];
    logic [31:0] m_pc;

    logic [99:0] obs;
    assign obs = {out_valid, out_inst, out_pc_plus_4, count, inst_addr};

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(BASE)) dut (
        .clk(clk), .reset(reset), .inst_addr(inst_addr), .inst(inst),
        .imem_ready(imem_ready), .redirect_en(redirect_en),
        .redirect_pc(redirect_pc), .halted(halted), .out_valid(out_valid),
        .out_ready(out_ready), .out_inst(out_inst),
        .out_pc_plus_4(out_pc_plus_4), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [99:0] exp_vec();
        logic        v;
        logic [31:0] i;
        logic [31:0] p;
        v = 1'b0; i = 32'd0; p = 32'd0;
        if (q.size() > 0) begin
            v = 1'b1; i = q[0][63:32]; p = q[0][31:0];
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        else if (imem_ready && !halted && !redirect_en && out_ready && !reset) begin
            v = 1'b1; i = inst; p = m_pc + 32'd4;
        end
`endif
        return {v, i, p, CNT_W'(q.size()), m_pc};
    endfunction

    task automatic model_step();
        bit pop, push, byp;
        if (reset) begin
            q.delete();
            m_pc = BASE;
        end else if (redirect_en) begin
            q.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            pop  = (q.size() > 0) && out_ready;
            push = imem_ready && !halted && ((q.size() < DEPTH) || pop);
            byp  = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
            byp  = push && out_ready && (q.size() == 0);
`endif
            if (pop) void'(q.pop_front());
            if (push && !byp) q.push_back({inst, m_pc + 32'd4});
            if (push) m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic apply(input logic rst, input logic rdy, input logic ordy,
                         input logic redir, input logic [31:0] rpc, input logic hlt);
        reset = rst; imem_ready = rdy; out_ready = ordy;
        redirect_en = redir; redirect_pc = rpc; halted = hlt;
        inst = $urandom;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        apply(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        apply(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        tick();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        checks++;
        if (obs !== {1'b0, 32'd0, 32'd0, 3'd0, BASE}) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", obs, {1'b0, 32'd0, 32'd0, 3'd0, BASE});
        end
    endtask

    task automatic test_stream();
        logic [31:0] nxt;
        logic [99:0] e;
        nxt = BASE + 32'd4;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            apply(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
            e = exp_vec();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL stream_model: got %h expected %h", obs, e); end
            checks++;
            if (inst_addr !== BASE + 32'(4 * i)) begin
                errors++; $display("FAIL stream_addr: got %h expected %h", inst_addr, BASE + 32'(4 * i));
            end
            if (i >= 1) begin
                checks++;
                if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_gap: got %b expected 1", out_valid); end
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (out_pc_plus_4 !== nxt) begin
                    errors++; $display("FAIL stream_order: got %h expected %h", out_pc_plus_4, nxt);
                end
                nxt = nxt + 32'd4;
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] nxt;
        logic [99:0] e;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
            e = exp_vec();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL bp_model: got %h expected %h", obs, e); end
            tick();
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        checks++;
        if (count !== 3'd4 || inst_addr !== BASE + 32'd16) begin
            errors++; $display("FAIL bp_full: got count=%0d addr=%h expected count=4 addr=%h", count, inst_addr, BASE + 32'd16);
        end
        nxt = BASE + 32'd4;
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || out_pc_plus_4 !== nxt) begin
                errors++; $display("FAIL bp_drain: got v=%b pc4=%h expected v=1 pc4=%h", out_valid, out_pc_plus_4, nxt);
            end
            nxt = nxt + 32'd4;
            tick();
        end
        apply(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || inst_addr !== BASE + 32'd16) begin
            errors++; $display("FAIL bp_empty: got v=%b addr=%h expected v=0 addr=%h", out_valid, inst_addr, BASE + 32'd16);
        end
        apply(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_pc_plus_4 !== BASE + 32'd20 || count !== 3'd1) begin
            errors++; $display("FAIL bp_resume: got v=%b pc4=%h cnt=%0d expected v=1 pc4=%h cnt=1", out_valid, out_pc_plus_4, count, BASE + 32'd20);
        end
    endtask

    task automatic test_redirect();
        logic [99:0] e;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
            tick();
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        checks++;
        if (count !== 3'd3) begin errors++; $display("FAIL redir_fill: got %0d expected 3", count); end
        apply(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_1003, 1'b0);
        e = exp_vec();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL redir_model: got %h expected %h", obs, e); end
        tick();
        apply(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || inst_addr !== 32'h0000_1000) begin
            errors++; $display("FAIL redir_flush: got cnt=%0d v=%b addr=%h expected cnt=0 v=0 addr=00001000", count, out_valid, inst_addr);
        end
        tick();
        apply(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_pc_plus_4 !== 32'h0000_1004 || count !== 3'd1) begin
            errors++; $display("FAIL redir_target: got v=%b pc4=%h cnt=%0d expected v=1 pc4=00001004 cnt=1", out_valid, out_pc_plus_4, count);
        end
    endtask

    task automatic test_imem_toggle();
        logic [31:0] nxt;
        logic [99:0] e;
        int acc;
        nxt = BASE + 32'd4;
        acc = 0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            apply(1'b0, (i % 2 == 0) && (i < 8), 1'b1, 1'b0, 32'd0, 1'b0);
            e = exp_vec();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL toggle_model: got %h expected %h", obs, e); end
            if (out_valid === 1'b1) begin
                acc++;
                checks++;
                if (out_pc_plus_4 !== nxt) begin
                    errors++; $display("FAIL toggle_order: got %h expected %h", out_pc_plus_4, nxt);
                end
                nxt = nxt + 32'd4;
            end
            tick();
        end
        apply(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        checks++;
        if (acc != 4 || inst_addr !== BASE + 32'd16) begin
            errors++; $display("FAIL toggle_count: got acc=%0d addr=%h expected acc=4 addr=%h", acc, inst_addr, BASE + 32'd16);
        end
    endtask

    task automatic test_halt();
        logic [99:0] e;
        int acc;
        acc = 0;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
            tick();
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        checks++;
        if (count !== 3'd2) begin errors++; $display("FAIL halt_fill: got %0d expected 2", count); end
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
            e = exp_vec();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL halt_model: got %h expected %h", obs, e); end
            if (out_valid === 1'b1) acc++;
            tick();
        end
        apply(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || inst_addr !== BASE + 32'd8 || acc != 2) begin
            errors++; $display("FAIL halt_drain: got v=%b cnt=%0d addr=%h acc=%0d expected v=0 cnt=0 addr=%h acc=2", out_valid, count, inst_addr, acc, BASE + 32'd8);
        end
        apply(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_2000, 1'b1);
        tick();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        checks++;
        if (inst_addr !== 32'h0000_2000 || count !== 3'd0) begin
            errors++; $display("FAIL halt_redirect: got addr=%h cnt=%0d expected addr=00002000 cnt=0", inst_addr, count);
        end
    endtask

    task automatic test_wrap();
        apply(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        tick();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        checks++;
        if (inst_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_load: got %h expected fffffffc", inst_addr); end
        apply(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        checks++;
        if (inst_addr !== 32'd0 || out_pc_plus_4 !== 32'd0 || out_valid !== 1'b1 || count !== 3'd1) begin
            errors++; $display("FAIL wrap_push: got addr=%h pc4=%h v=%b cnt=%0d expected addr=0 pc4=0 v=1 cnt=1", inst_addr, out_pc_plus_4, out_valid, count);
        end
        apply(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3000, 1'b0);
        tick();
        apply(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
`ifdef FETCH_QUEUE_BYPASS_EN
        checks++;
        if (out_valid !== 1'b1 || out_inst !== inst || out_pc_plus_4 !== 32'h0000_3004 || count !== 3'd0) begin
            errors++; $display("FAIL bypass_same_cycle: got v=%b inst=%h pc4=%h cnt=%0d expected v=1 inst=%h pc4=00003004 cnt=0", out_valid, out_inst, out_pc_plus_4, count, inst);
        end
        tick();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        checks++;
        if (count !== 3'd0 || inst_addr !== 32'h0000_3004) begin
            errors++; $display("FAIL bypass_consumed: got cnt=%0d addr=%h expected cnt=0 addr=00003004", count, inst_addr);
        end
`else
        checks++;
        if (out_valid !== 1'b0 || out_inst !== 32'd0) begin
            errors++; $display("FAIL no_bypass: got v=%b inst=%h expected v=0 inst=0", out_valid, out_inst);
        end
        tick();
`endif
    endtask

    task automatic test_random();
        logic [99:0] e;
        for (int i = 0; i < 400; i++) begin
            apply($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0,
                  $urandom, $urandom_range(0, 9) == 0);
            e = exp_vec();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL random_model cycle %0d: got %h expected %h", i, obs, e); end
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; imem_ready = 1'b0; out_ready = 1'b0;
        redirect_en = 1'b0; redirect_pc = 32'd0; halted = 1'b0; inst = 32'd0;
        m_pc = BASE;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_imem_toggle();
        test_halt();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage with a small prefetch FIFO, sitting directly upstream of the core's IF/ID pipeline register. It owns the fetch PC, drives the instruction memory address, and buffers fetched words with their PC+4. Decode consumes entries through a valid/ready handshake, so decode stalls such as `cache_done` low never drop or duplicate instructions. Branch and jump redirects flush the queue and restart fetch at the new target.

## Interface
- `DEPTH`, 4: queue entries; power of two, 2..16.
- `RESET_PC`, 32'h0000_0000: fetch PC after reset; word aligned.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `inst_addr`  out  32  fetch PC presented to instruction memory.
- `inst`  in  32  instruction word at `inst_addr`, valid in the same cycle.
- `imem_ready`  in  1  `inst` is valid this cycle; 0 means the memory is stalling.
- `redirect_en`  in  1  flush the queue and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  branch/jump target; bits [1:0] are ignored and forced to 0.
- `halted`  in  1  halt from syscall; while high, no new fetches are issued.
- `out_valid`  out  1  head entry is available to decode.
- `out_ready`  in  1  decode accepts the head entry this cycle.
- `out_inst`  out  32  head instruction.
- `out_pc_plus_4`  out  32  PC of the head instruction, plus 4.
- `count`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- State: `fetch_pc`, plus a circular buffer of DEPTH entries of {inst, pc+4} with read and write pointers of $clog2(DEPTH) bits. Pointers wrap modulo DEPTH. `count` is tracked separately.
- `inst_addr` = `fetch_pc` at all times.
- Push: occurs when `imem_ready` && !`full` && !`halted` && !`redirect_en`.
  - Writes {`inst`, `fetch_pc`+4} at the write pointer.
  - Sets `fetch_pc` to `fetch_pc`+4. Addition is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Pop: occurs when `out_valid` && `out_ready` && !`redirect_en`. Advances the read pointer.
- Push and pop in the same cycle leave `count` unchanged. Push is allowed when full only if a pop happens in that same cycle: full && pop permits push.
- `full`: `count`==DEPTH. `empty`: `count`==0. At full, `fetch_pc` holds and `inst` is ignored.
- Redirect has the highest priority. On an edge with `redirect_en`=1:
  - pointers and `count` clear to 0;
  - `fetch_pc` is loaded with {`redirect_pc`[31:2], 2'b00};
  - no push and no pop happen that cycle, whatever `out_ready` and `imem_ready` are.
- Halt: `halted`=1 blocks push only. Queued entries still drain to decode. A redirect while halted still flushes the queue and loads the PC.
- `out_valid` = !`empty`. When `out_valid`=0, `out_inst` and `out_pc_plus_4` are driven to 0.
- Reset overrides everything: pointers and `count` go to 0, `fetch_pc` to RESET_PC.

## Timing
- Reset values: `inst_addr`=RESET_PC, `out_valid`=0, `out_inst`=0, `out_pc_plus_4`=0, `count`=0.
- Default latency: a word pushed at edge N is visible on `out_*` after edge N, i.e. one cycle from `imem_ready` to `out_valid`.
- Throughput: one instruction per cycle when `imem_ready` and `out_ready` are held high.
- Redirect: the first target instruction is pushed on the first edge after the redirect edge. It appears on `out_*` one cycle after that.
- Handshake: `out_valid`/`out_inst` are stable until popped, except when a redirect flushes them. `out_valid` never drops without a pop, a redirect, or reset.

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined: when the queue is empty, a push is legal, and `out_ready`=1, the fetched word is driven combinationally:
  - `out_valid`=1, `out_inst`=`inst`, `out_pc_plus_4`=`fetch_pc`+4;
  - it is consumed without being written to the queue, and `count` stays 0;
  - latency is 0 cycles.
- Not defined: no combinational path from `inst`/`imem_ready` to `out_*`; minimum latency is 1 cycle.

## Test plan
- Reset with RESET_PC=32'h0040_0000, `imem_ready`=1, `out_ready`=1 → `inst_addr` steps 0x400000, 0x400004, …; `out_pc_plus_4` sequence 0x400004, 0x400008, … with no gaps after the first word.
- `out_ready`=0 for 6 cycles with DEPTH=4 → `count` saturates at 4 and `inst_addr` holds at base+16. Then `out_ready`=1 → the 4 entries drain in order, then fetch resumes at base+16.
- Redirect to 32'h0000_1003 while `count`=3 and `out_ready`=1 → next cycle `count`=0, `out_valid`=0, `inst_addr`=0x1000; the first pushed entry has `out_pc_plus_4`=0x1004.
- `imem_ready` toggling 1,0,1,0 → exactly one push per ready cycle; PCs stay contiguous with no duplicates.
- `halted`=1 with `count`=2 → the 2 entries drain, then `out_valid`=0 and `inst_addr` is frozen.
- `fetch_pc`=32'hFFFF_FFFC push → `inst_addr` becomes 0 and `out_pc_plus_4`=0. With BYPASS_EN and an empty queue → `out_inst` equals `inst` in the same cycle.
